// File: rtl/reg_scoreboard_pkg.sv
// ============================================================================
// reg_scoreboard_pkg
// Shared forwarding-select encodings and register-address types.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_scoreboard_pkg;
   typedef logic [4:0] reg_addr_t;
   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_GRF = 2'd0;
   localparam fwd_sel_t FWD_E   = 2'd1;
   localparam fwd_sel_t FWD_M   = 2'd2;
endpackage

`default_nettype wire

// File: rtl/reg_scoreboard_if.sv
// ============================================================================
// reg_scoreboard_if
// D-stage request and hazard/forwarding response bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_scoreboard_if
   import reg_scoreboard_pkg::*;
#(
   parameter int TW    = 2,
   parameter int CNT_W = 32
);
   logic             d_valid;
   reg_addr_t        d_rs;
   reg_addr_t        d_rt;
   logic [TW-1:0]    d_rs_tuse;
   logic [TW-1:0]    d_rt_tuse;
   reg_addr_t        d_dst;
   logic [TW-1:0]    d_tnew;
   logic             flush;
   logic             stall;
   fwd_sel_t         fwd_rs;
   fwd_sel_t         fwd_rt;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew, flush,
      input  stall, fwd_rs, fwd_rt, stall_count
   );

   modport slave (
      input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew, flush,
      output stall, fwd_rs, fwd_rt, stall_count
   );
endinterface

`default_nettype wire

// File: rtl/reg_scoreboard_sb_src_check.sv
// ============================================================================
// sb_src_check
// Resolves one D-stage source against the E/M/W entries: hazard and fwd select.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sb_src_check
   import reg_scoreboard_pkg::*;
#(
   parameter int TW         = 2,
   parameter int ENABLE_FWD = 1
) (
   input  wire reg_addr_t     addr_i,
   input  wire logic [TW-1:0] tuse_i,
   input  wire logic          e_valid_i,
   input  wire reg_addr_t     e_dst_i,
   input  wire logic [TW-1:0] e_tnew_i,
   input  wire logic          m_valid_i,
   input  wire reg_addr_t     m_dst_i,
   input  wire logic [TW-1:0] m_tnew_i,
   input  wire logic          w_valid_i,
   input  wire reg_addr_t     w_dst_i,
   input  wire logic [TW-1:0] w_tnew_i,
   output fwd_sel_t           fwd_o,
   output logic               hazard_o
);
   localparam logic [TW-1:0] TUSE_NONE = '1;

   // Youngest match wins outright; an older ready entry never overrides it.
   always_comb begin
      hazard_o = 1'b0;
      fwd_o    = FWD_GRF;
      if (addr_i != '0 && tuse_i != TUSE_NONE) begin
         if (e_valid_i && e_dst_i == addr_i) begin
            if (e_tnew_i > tuse_i) begin
               hazard_o = 1'b1;
            end else if (e_tnew_i == '0) begin
               if (ENABLE_FWD != 0) fwd_o = FWD_E;
               else                 hazard_o = 1'b1;
            end
         end else if (m_valid_i && m_dst_i == addr_i) begin
            if (m_tnew_i > tuse_i) begin
               hazard_o = 1'b1;
            end else if (m_tnew_i == '0) begin
               if (ENABLE_FWD != 0) fwd_o = FWD_M;
               else                 hazard_o = 1'b1;
            end
         end else if (w_valid_i && w_dst_i == addr_i) begin
            if (w_tnew_i > tuse_i) hazard_o = 1'b1;
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// reg_scoreboard
// GRF hazard unit: tracks in-flight writes in E/M/W, stalls D or selects forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int TW         = 2,
   parameter int ENABLE_FWD = 1,
   parameter int CNT_W      = 32
) (
   input  wire logic       clk,
   input  wire logic       reset,
   reg_scoreboard_if.slave sb
);
   logic             e_valid_q, e_valid_d, m_valid_q, m_valid_d, w_valid_q, w_valid_d;
   reg_addr_t        e_dst_q, e_dst_d, m_dst_q, m_dst_d, w_dst_q, w_dst_d;
   logic [TW-1:0]    e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d, w_tnew_q, w_tnew_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic     hz_rs, hz_rt, stall;
   fwd_sel_t fwd_rs_raw, fwd_rt_raw;

   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
      return (t == '0) ? t : t - TW'(1);
   endfunction

   sb_src_check #(.TW(TW), .ENABLE_FWD(ENABLE_FWD)) u_rs (
      .addr_i(sb.d_rs), .tuse_i(sb.d_rs_tuse),
      .e_valid_i(e_valid_q), .e_dst_i(e_dst_q), .e_tnew_i(e_tnew_q),
      .m_valid_i(m_valid_q), .m_dst_i(m_dst_q), .m_tnew_i(m_tnew_q),
      .w_valid_i(w_valid_q), .w_dst_i(w_dst_q), .w_tnew_i(w_tnew_q),
      .fwd_o(fwd_rs_raw), .hazard_o(hz_rs)
   );

   sb_src_check #(.TW(TW), .ENABLE_FWD(ENABLE_FWD)) u_rt (
      .addr_i(sb.d_rt), .tuse_i(sb.d_rt_tuse),
      .e_valid_i(e_valid_q), .e_dst_i(e_dst_q), .e_tnew_i(e_tnew_q),
      .m_valid_i(m_valid_q), .m_dst_i(m_dst_q), .m_tnew_i(m_tnew_q),
      .w_valid_i(w_valid_q), .w_dst_i(w_dst_q), .w_tnew_i(w_tnew_q),
      .fwd_o(fwd_rt_raw), .hazard_o(hz_rt)
   );

   assign stall          = (hz_rs | hz_rt) & sb.d_valid;
   assign sb.stall       = stall;
   assign sb.fwd_rs      = stall ? FWD_GRF : fwd_rs_raw;
   assign sb.fwd_rt      = stall ? FWD_GRF : fwd_rt_raw;
   assign sb.stall_count = stall_count_q;

   // Flush kills E and M but lets the old M entry retire into W.
   always_comb begin
      w_valid_d = m_valid_q;
      w_dst_d   = m_dst_q;
      w_tnew_d  = sat_dec(m_tnew_q);
      m_valid_d = e_valid_q & ~sb.flush;
      m_dst_d   = sb.flush ? '0 : e_dst_q;
      m_tnew_d  = sb.flush ? '0 : sat_dec(e_tnew_q);
      e_valid_d = sb.d_valid & ~stall & (sb.d_dst != '0) & ~sb.flush;
      e_dst_d   = e_valid_d ? sb.d_dst  : '0;
      e_tnew_d  = e_valid_d ? sb.d_tnew : '0;
      stall_count_d = stall_count_q;
      if (stall && stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_valid_q     <= 1'b0;
         e_dst_q       <= '0;
         e_tnew_q      <= '0;
         m_valid_q     <= 1'b0;
         m_dst_q       <= '0;
         m_tnew_q      <= '0;
         w_valid_q     <= 1'b0;
         w_dst_q       <= '0;
         w_tnew_q      <= '0;
         stall_count_q <= '0;
      end else begin
         e_valid_q     <= e_valid_d;
         e_dst_q       <= e_dst_d;
         e_tnew_q      <= e_tnew_d;
         m_valid_q     <= m_valid_d;
         m_dst_q       <= m_dst_d;
         m_tnew_q      <= m_tnew_d;
         w_valid_q     <= w_valid_d;
         w_dst_q       <= w_dst_d;
         w_tnew_q      <= w_tnew_d;
         stall_count_q <= stall_count_d;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// tb_reg_scoreboard
// Directed scoreboard bench for reg_scoreboard (TW=2, ENABLE_FWD=1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   typedef struct {
      string      tag;
      logic       stall;
      logic [1:0] fwd_rs;
      logic [1:0] fwd_rt;
   } exp_t;

   exp_t exp_q[$];

   reg_scoreboard_if #(.TW(2), .CNT_W(32)) sb_if ();

   reg_scoreboard #(.TW(2), .ENABLE_FWD(1), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (rst),
      .sb    (sb_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] rsu,
                        input logic [4:0] rt, input logic [1:0] rtu,
                        input logic [4:0] dst, input logic [1:0] tn, input logic fl);
      sb_if.d_valid   = v;
      sb_if.d_rs      = rs;
      sb_if.d_rs_tuse = rsu;
      sb_if.d_rt      = rt;
      sb_if.d_rt_tuse = rtu;
      sb_if.d_dst     = dst;
      sb_if.d_tnew    = tn;
      sb_if.flush     = fl;
   endtask

   // Drive one D-stage cycle, queue its expected response, compare at negedge.
   task automatic step(input string tag, input logic v, input logic [4:0] rs,
                       input logic [1:0] rsu, input logic [4:0] rt, input logic [1:0] rtu,
                       input logic [4:0] dst, input logic [1:0] tn, input logic fl,
                       input logic es, input logic [1:0] ers, input logic [1:0] ert);
      exp_t e;
      drive(v, rs, rsu, rt, rtu, dst, tn, fl);
      exp_q.push_back('{tag, es, ers, ert});
      @(negedge clk);
      e = exp_q.pop_front();
      chk({e.tag, "_stall"},  32'(sb_if.stall),  32'(e.stall));
      chk({e.tag, "_fwd_rs"}, 32'(sb_if.fwd_rs), 32'(e.fwd_rs));
      chk({e.tag, "_fwd_rt"}, 32'(sb_if.fwd_rt), 32'(e.fwd_rt));
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk      = 1'b0;
      rst      = 1'b1;
      checks   = 0;
      failures = 0;
      drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);

      @(negedge clk);
      chk("rst_stall",  32'(sb_if.stall),  32'd0);
      chk("rst_fwd_rs", 32'(sb_if.fwd_rs), 32'd0);
      chk("rst_fwd_rt", 32'(sb_if.fwd_rt), 32'd0);
      chk("rst_count",  sb_if.stall_count, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // load-use: tnew=2 producer, tuse=1 consumer stalls once
      step("lw8",      1, 0, 3,  0, 3, 8,  2, 0,  0, 0, 0);
      step("addu_stl", 1, 8, 1,  0, 3, 11, 1, 0,  1, 0, 0);
      step("addu_go",  1, 8, 1,  0, 3, 11, 1, 0,  0, 0, 0);
      chk("count_after_lw", sb_if.stall_count, 32'd1);

      // tnew=1 producer vs tuse=0 reader: stall, then forward from M
      step("beq_stl",  1, 11, 0, 8, 0, 0, 0, 0,  1, 0, 0);
      step("beq_fwdM", 1, 11, 0, 8, 0, 0, 0, 0,  0, 2, 0);

      // E and M both write $10: E wins, then M wins over W
      step("w10_a",    1, 0, 3,  0, 3, 10, 0, 0,  0, 0, 0);
      step("w10_b",    1, 0, 3,  0, 3, 10, 0, 0,  0, 0, 0);
      step("rd10_E",   1, 10, 0, 10, 2, 0, 0, 0,  0, 1, 1);
      step("rd10_M",   1, 10, 0, 0, 3,  0, 0, 0,  0, 2, 0);

      // $0 and tuse=unused never hazard; invalid D never stalls
      step("lw12",     1, 0, 3,  0, 3, 12, 2, 0,  0, 0, 0);
      step("rd0_unus", 1, 0, 0,  12, 3, 0, 0, 0,  0, 0, 0);
      step("invalid",  0, 12, 0, 0, 3,  0, 0, 0,  0, 0, 0);

      // flush drops E/M; old M (tnew=3 producer) still reaches W
      step("w14",      1, 0, 3,  0, 3, 14, 3, 0,  0, 0, 0);
      step("lw8b",     1, 0, 3,  0, 3, 8,  2, 0,  0, 0, 0);
      step("flush",    1, 8, 0,  0, 3, 13, 1, 1,  1, 0, 0);
      step("post_fl",  1, 8, 0,  14, 0, 0, 0, 0,  1, 0, 0);
      step("drained",  1, 8, 0,  14, 0, 0, 0, 0,  0, 0, 0);
      chk("count_after_fl", sb_if.stall_count, 32'd4);

      // asynchronous reset while stalled
      step("lw8c",     1, 0, 3,  0, 3, 8,  2, 0,  0, 0, 0);
      step("rd8_stl",  1, 8, 0,  0, 3, 0,  0, 0,  1, 0, 0);
      #1;
      chk("pre_rst_stall", 32'(sb_if.stall), 32'd1);
      chk("pre_rst_count", sb_if.stall_count, 32'd5);
      rst = 1'b1;
      #1;
      chk("arst_stall",  32'(sb_if.stall),  32'd0);
      chk("arst_fwd_rs", 32'(sb_if.fwd_rs), 32'd0);
      chk("arst_fwd_rt", 32'(sb_if.fwd_rt), 32'd0);
      chk("arst_count",  sb_if.stall_count, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
